// File: rtl/rr_mux5_sched_if.sv
// Request/data/grant bundle between the five requesters and the shared
// 5x1 select datapath of rr_mux5_sched.
interface rr_mux5_sched_if;
    logic [4:0] req;
    logic [4:0] i;
    logic [4:0] gnt;
    logic [2:0] s;
    logic       y;
    logic       vld;
    logic       busy;

    modport master (
        output req,
        output i,
        input  gnt,
        input  s,
        input  y,
        input  vld,
        input  busy
    );

    modport slave (
        input  req,
        input  i,
        output gnt,
        output s,
        output y,
        output vld,
        output busy
    );
endinterface

// File: rtl/rr_mux5_sched.sv
// Round-robin scheduler sharing one 5x1 select datapath between five
// requesters; each grant is bounded by HOLD_MAX consecutive cycles.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no grant outstanding; gnt=0, busy=0; waits for any req
//   ST_GRANT | one requester owns the datapath; hold timer counts down
module rr_mux5_sched #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    rr_mux5_sched_if.slave  bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Timer is loaded with HOLD_MAX-1 and the grant expires at terminal count 0.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_MAX - 1);

    logic [0:0] state;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic [2:0] ptr;
    logic [3:0] hold_left;
    logic       y_q;
    logic       vld_q;

    logic [2:0] ptr_adv;
    logic [3:0] idle_pick;
    logic [3:0] rel_pick;
    logic       owner_req;
    logic       hold_tc;
    logic       rel;

    // Codes 5..7 are unreachable, but a forced one must read as 0.
    function automatic logic mux5(input logic [4:0] d, input logic [2:0] k);
        logic r;
        case (k)
            3'd0:    r = d[0];
            3'd1:    r = d[1];
            3'd2:    r = d[2];
            3'd3:    r = d[3];
            3'd4:    r = d[4];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Returns {found, index}; the lowest offset from start wins, so scan
    // from the farthest offset down and let nearer hits overwrite.
    function automatic logic [3:0] pick(input logic [4:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [3:0] sum;
        logic [2:0] cand;
        res = 4'b0;
        for (int k = 4; k >= 0; k--) begin
            sum  = {1'b0, start} + 4'(k);
            cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (mux5(r, cand)) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    function automatic logic [4:0] onehot5(input logic [2:0] k);
        return 5'(5'd1 << k);
    endfunction

    always_comb begin
        ptr_adv   = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
        idle_pick = pick(bus.req, ptr);
        rel_pick  = pick(bus.req, ptr_adv);
        owner_req = mux5(bus.req, sel);
        hold_tc   = (hold_left == 4'd0);
        rel       = !owner_req || hold_tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= 5'b0;
            sel       <= 3'd0;
            ptr       <= 3'd0;
            hold_left <= 4'd0;
            y_q       <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            y_q   <= (gnt != 5'b0) ? mux5(bus.i, sel) : 1'b0;
            vld_q <= (gnt != 5'b0);

            case (state)
                ST_IDLE: begin
                    if (idle_pick[3]) begin
                        state     <= ST_GRANT;
                        gnt       <= onehot5(idle_pick[2:0]);
                        sel       <= idle_pick[2:0];
                        hold_left <= HOLD_LOAD;
                    end
                end
                ST_GRANT: begin
                    if (!rel) begin
                        hold_left <= hold_left - 4'd1;
                    end else begin
                        // Back-to-back handoff: the search already uses the advanced pointer.
                        ptr <= ptr_adv;
                        if (rel_pick[3]) begin
                            gnt       <= onehot5(rel_pick[2:0]);
                            sel       <= rel_pick[2:0];
                            hold_left <= HOLD_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= 5'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 5'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.s    = sel;
    assign bus.y    = y_q;
    assign bus.vld  = vld_q;
    assign bus.busy = (state == ST_GRANT);

    a_hold_range: assert property (@(posedge clk) (HOLD_MAX >= 1) && (HOLD_MAX <= 15));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_sel:    assert property (@(posedge clk) disable iff (rst) (gnt != 5'b0) |-> gnt[sel]);
    a_busy:       assert property (@(posedge clk) disable iff (rst) bus.busy == (gnt != 5'b0));
    a_sel_range:  assert property (@(posedge clk) disable iff (rst) sel <= 3'd4);

endmodule
